alu_exec: RTL and testbench

Multi-cycle execute unit that consumes the 4-bit `alu_c` operation code produced by the ALU control decoder and performs the selected operation on two operands. It sits in the EX stage between the register-read/immediate mux and the EX/MEM boundary. A valid/ready handshake on both sides lets single-cycle operations and the iterative shift-add multiplier share one result path.

---
 rtl/alu_exec.sv | 183 ++++++++++++++++++
 tb/tb_alu_exec.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: EX-stage execute unit with valid/ready handshakes on both sides.
// Single-cycle ops: add, sub, srl, lui. Unsupported codes raise illegal.
// Optional iterative shift-add multiplier, built when ALU_EXEC_MUL_EN is defined;
// otherwise code 1000 is treated as illegal.
module alu_exec #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_c,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal
);

   localparam logic [3:0] OpAdd = 4'b0010;
   localparam logic [3:0] OpSub = 4'b0110;
   localparam logic [3:0] OpMul = 4'b1000;
   localparam logic [3:0] OpSrl = 4'b1001;
   localparam logic [3:0] OpLui = 4'b1010;

`ifdef ALU_EXEC_MUL_EN
   typedef enum logic [1:0] {StIdle = 2'd0, StMul = 2'd1, StDone = 2'd2} state_e;
`else
   typedef enum logic [1:0] {StIdle = 2'd0, StDone = 2'd2} state_e;
`endif

   state_e state_q, state_d;

   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             overflow_q, overflow_d;
   logic             illegal_q, illegal_d;

   logic             accept;
   logic             is_mul;
   logic [WIDTH-1:0] sc_res;
   logic             sc_ovf;
   logic             sc_ill;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] b_lo;

   assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == StDone);
   assign result    = result_q;
   assign zero      = zero_q;
   assign overflow  = overflow_q;
   assign illegal   = illegal_q;

   // Decode the incoming code and compute the single-cycle result from the live operands.
   always_comb begin
      sum    = a + b;
      diff   = a - b;
      b_lo   = '0;
      b_lo[15:0] = b[15:0];
      sc_res = '0;
      sc_ovf = 1'b0;
      sc_ill = 1'b0;
      is_mul = 1'b0;
      case (alu_c)
         OpAdd: begin
            sc_res = sum;
            sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OpSub: begin
            sc_res = diff;
            sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OpSrl: sc_res = b >> shamt;
         OpLui: sc_res = b_lo << (WIDTH - 16);
`ifdef ALU_EXEC_MUL_EN
         OpMul: is_mul = 1'b1;
`endif
         default: sc_ill = 1'b1;
      endcase
   end

`ifdef ALU_EXEC_MUL_EN
   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CntW-1:0]    cnt_q;
   logic [2*WIDTH-1:0] acc_step;
   logic               mul_last;

   // One shift-add iteration; mul_last marks the WIDTH-th iteration.
   always_comb begin
      acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mul_last = (cnt_q == CntW'(WIDTH - 1));
   end

   // Multiplier datapath: load operands on accept, iterate while in MUL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else if (accept && is_mul) begin
         acc_q    <= '0;
         mcand_q  <= {{WIDTH{1'b0}}, a};
         mplier_q <= b;
         cnt_q    <= '0;
      end else if (state_q == StMul) begin
         acc_q    <= acc_step;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
      end
   end
`endif

   // Next-state and result-register update.
   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;
      illegal_d  = illegal_q;

      if (accept) begin
         if (is_mul) begin
`ifdef ALU_EXEC_MUL_EN
            state_d = StMul;
`endif
         end else begin
            state_d    = StDone;
            result_d   = sc_res;
            zero_d     = (sc_res == '0);
            overflow_d = sc_ovf;
            illegal_d  = sc_ill;
         end
      end else begin
         case (state_q)
`ifdef ALU_EXEC_MUL_EN
            StMul: begin
               if (mul_last) begin
                  state_d    = StDone;
                  result_d   = acc_step[WIDTH-1:0];
                  zero_d     = (acc_step[WIDTH-1:0] == '0);
                  overflow_d = |acc_step[2*WIDTH-1:WIDTH];
                  illegal_d  = 1'b0;
               end
            end
`endif
            StDone: begin
               if (out_ready) state_d = StIdle;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // State and result registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         result_q   <= '0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         overflow_q <= overflow_d;
         illegal_q  <= illegal_d;
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec (WIDTH = 32).
// Mul checks are built only when ALU_EXEC_MUL_EN is defined.
module tb_alu_exec;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_c;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        illegal;

   int checks = 0;
   int errors = 0;
   int bad;

   alu_exec #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_c     (alu_c),
      .a         (a),
      .b         (b),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   initial begin
      rst_n = 1'b0; in_valid = 1'b0; alu_c = 4'b0; a = '0; b = '0; shamt = '0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // add with signed overflow
      in_valid = 1'b1; alu_c = 4'b0010; a = 32'h7FFF_FFFF; b = 32'd1; out_ready = 1'b1;
      @(negedge clk);
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_result", result, 32'h8000_0000);
      chk("add_ovf", 32'(overflow), 32'd1);
      chk("add_zero", 32'(zero), 32'd0);
      chk("add_in_ready", 32'(in_ready), 32'd1);

      // sub to zero, back-to-back
      alu_c = 4'b0110; a = 32'd5; b = 32'd5;
      @(negedge clk);
      chk("sub_valid", 32'(out_valid), 32'd1);
      chk("sub_result", result, 32'd0);
      chk("sub_zero", 32'(zero), 32'd1);
      chk("sub_ovf", 32'(overflow), 32'd0);
      chk("sub_in_ready", 32'(in_ready), 32'd1);

      // srl back-to-back
      alu_c = 4'b1001; a = 32'hDEAD_BEEF; b = 32'hF000_0000; shamt = 5'd4;
      @(negedge clk);
      chk("srl_valid", 32'(out_valid), 32'd1);
      chk("srl_result", result, 32'h0F00_0000);
      chk("srl_zero", 32'(zero), 32'd0);
      chk("srl_in_ready", 32'(in_ready), 32'd1);

      // sub with signed overflow
      alu_c = 4'b0110; a = 32'h8000_0000; b = 32'd1;
      @(negedge clk);
      chk("subovf_result", result, 32'h7FFF_FFFF);
      chk("subovf_ovf", 32'(overflow), 32'd1);

      // retire, back to idle
      in_valid = 1'b0;
      @(negedge clk);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_hold_result", result, 32'h7FFF_FFFF);

      // lui held under backpressure; a pending add must wait
      in_valid = 1'b1; alu_c = 4'b1010; b = 32'h0000_1234; out_ready = 1'b0;
      @(negedge clk);
      alu_c = 4'b0010; a = 32'd1; b = 32'd1;
      for (int i = 0; i < 3; i++) begin
         chk("lui_valid", 32'(out_valid), 32'd1);
         chk("lui_result", result, 32'h1234_0000);
         chk("lui_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("lui_release_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk("after_lui_add", result, 32'd2);
      chk("after_lui_valid", 32'(out_valid), 32'd1);

      // illegal code, then a legal op clears the flag
      alu_c = 4'b1111; a = 32'd3; b = 32'd4;
      @(negedge clk);
      chk("ill_flag", 32'(illegal), 32'd1);
      chk("ill_result", result, 32'd0);
      chk("ill_zero", 32'(zero), 32'd1);
      chk("ill_ovf", 32'(overflow), 32'd0);
      alu_c = 4'b0010;
      @(negedge clk);
      chk("ill_clear", 32'(illegal), 32'd0);
      chk("ill_next_result", result, 32'd7);

`ifdef ALU_EXEC_MUL_EN
      // mul 0x10000 * 0x10000: low half zero, high half nonzero
      alu_c = 4'b1000; a = 32'h0001_0000; b = 32'h0001_0000;
      @(negedge clk);
      in_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("mul1_busy_cycles", 32'(bad), 32'd0);
      chk("mul1_valid", 32'(out_valid), 32'd1);
      chk("mul1_result", result, 32'd0);
      chk("mul1_ovf", 32'(overflow), 32'd1);
      chk("mul1_zero", 32'(zero), 32'd1);

      // mul accepted directly from DONE while retiring the previous result
      in_valid = 1'b1; a = 32'd1234; b = 32'd5678;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mul2_retire", 32'(out_valid), 32'd0);
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("mul2_busy_cycles", 32'(bad), 32'd0);
      chk("mul2_valid", 32'(out_valid), 32'd1);
      chk("mul2_result", result, 32'd7006652);
      chk("mul2_ovf", 32'(overflow), 32'd0);
      chk("mul2_zero", 32'(zero), 32'd0);
      @(negedge clk);

      // reset 10 cycles into a mul aborts it
      in_valid = 1'b1; a = 32'd3; b = 32'd5;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
      end
      chk("abort_no_result", 32'(bad), 32'd0);
      chk("abort_result_kept", result, 32'd0);
`else
      // without the multiplier, code 1000 is illegal with one-cycle latency
      alu_c = 4'b1000; a = 32'd1234; b = 32'd5678;
      @(negedge clk);
      chk("nomul_valid", 32'(out_valid), 32'd1);
      chk("nomul_illegal", 32'(illegal), 32'd1);
      chk("nomul_result", result, 32'd0);
      chk("nomul_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("nomul_idle", 32'(out_valid), 32'd0);

      // reset while a result is pending drops it
      in_valid = 1'b1; alu_c = 4'b0010; a = 32'd9; b = 32'd1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("pend_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("pend_abort_valid", 32'(out_valid), 32'd0);
      chk("pend_abort_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("pend_after_ready", 32'(in_ready), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
